// File: rtl/cordic_rotator_seq_pkg.sv
// Shared CORDIC definitions: arctangent table, guard-bit count, FSM states
// and output saturation. Usable by any later vectoring-mode CORDIC.
// Build option: CORDIC_GAIN_COMP_EN adds a third FSM state for gain scaling.
package cordic_rotator_seq_pkg;

    // Integer guard bits on the x/y datapath; CORDIC gain * sqrt(2) < 4
    localparam int unsigned GUARD_BITS = 2;

    // Fixed-point scale of the high-precision arctangent table below
    localparam int unsigned ATAN_SCALE_BITS = 24;

`ifdef CORDIC_GAIN_COMP_EN
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ROTATE = 2'd1,
        ST_SCALE  = 2'd2
    } state_t;
`else
    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ROTATE = 1'b1
    } state_t;
`endif

    // atan(2^-idx)/pi scaled by 2^24; beyond idx 8 atan(x) ~= x is exact enough
    function automatic int unsigned atan_hi(input int unsigned idx);
        case (idx)
            32'd0:   atan_hi = 32'd4194304;
            32'd1:   atan_hi = 32'd2476042;
            32'd2:   atan_hi = 32'd1308273;
            32'd3:   atan_hi = 32'd664099;
            32'd4:   atan_hi = 32'd333339;
            32'd5:   atan_hi = 32'd166832;
            32'd6:   atan_hi = 32'd83436;
            32'd7:   atan_hi = 32'd41721;
            32'd8:   atan_hi = 32'd20861;
            default: atan_hi = 32'd5340354 >> idx;
        endcase
    endfunction

    // round(atan(2^-idx)/pi * 2^n_frac), valid for n_frac < 24
    function automatic int unsigned atan_lut(input int unsigned idx, input int unsigned n_frac);
        int unsigned sh;
        sh = ATAN_SCALE_BITS - n_frac;
        atan_lut = (atan_hi(idx) + (32'd1 << (sh - 32'd1))) >> sh;
    endfunction

    // Clamp to the signed Q0.n_frac range [-2^n_frac, 2^n_frac-1]
    function automatic logic signed [31:0] saturate(input logic signed [31:0] v,
                                                    input int unsigned n_frac);
        logic signed [31:0] hi;
        logic signed [31:0] lo;
        hi = $signed((32'd1 << n_frac) - 32'd1);
        lo = -$signed(32'd1 << n_frac);
        if (v > hi) begin
            saturate = hi;
        end else if (v < lo) begin
            saturate = lo;
        end else begin
            saturate = v;
        end
    endfunction

endpackage

// File: rtl/cordic_rotator_seq_quadrant_map.sv
// Combinational quadrant pre-rotation folding (x, y, z) into the +-pi/2 range
// so the micro-rotations only need to cover about +-0.55*pi.
module cordic_rotator_seq_quadrant_map
    import cordic_rotator_seq_pkg::*;
#(
    parameter int unsigned N_FRAC = 7
) (
    input  logic signed [N_FRAC:0]            x,
    input  logic signed [N_FRAC:0]            y,
    input  logic signed [N_FRAC:0]            z,
    output logic signed [N_FRAC+GUARD_BITS:0] x_map_c,
    output logic signed [N_FRAC+GUARD_BITS:0] y_map_c,
    output logic signed [N_FRAC:0]            z_map_c
);

    localparam int unsigned IW = N_FRAC + 1;
    localparam int unsigned W  = IW + GUARD_BITS;
    localparam logic signed [IW-1:0] HALF = IW'(32'd1 << (N_FRAC - 1));

    logic signed [W-1:0] x_ext;
    logic signed [W-1:0] y_ext;

    // Rotate by -+pi/2 when |z| >= 0.5, otherwise pass through
    always_comb begin
        x_ext   = {{GUARD_BITS{x[N_FRAC]}}, x};
        y_ext   = {{GUARD_BITS{y[N_FRAC]}}, y};
        x_map_c = x_ext;
        y_map_c = y_ext;
        z_map_c = z;
        case (z[N_FRAC -: 2])
            2'b01: begin
                x_map_c = -y_ext;
                y_map_c = x_ext;
                z_map_c = z - HALF;
            end
            2'b10: begin
                x_map_c = y_ext;
                y_map_c = -x_ext;
                z_map_c = z + HALF;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: rtl/cordic_rotator_seq.sv
// Iterative rotation-mode CORDIC: one micro-rotation per clock, quadrant
// pre-rotation for full +-pi coverage, saturated registered outputs.
// Build option: CORDIC_GAIN_COMP_EN adds one cycle scaling x/y by ~1/K.
module cordic_rotator_seq
    import cordic_rotator_seq_pkg::*;
#(
    parameter int unsigned N_FRAC = 7,
    parameter int unsigned N_ITER = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic signed [N_FRAC:0] x_i,
    input  logic signed [N_FRAC:0] y_i,
    input  logic signed [N_FRAC:0] z_i,
    input  logic                 data_in_valid_strobe_i,
    output logic signed [N_FRAC:0] x_o,
    output logic signed [N_FRAC:0] y_o,
    output logic signed [N_FRAC:0] z_o,
    output logic                 data_out_valid_strobe_o,
    output logic                 busy_o
);

    localparam int unsigned IW = N_FRAC + 1;
    localparam int unsigned W  = IW + GUARD_BITS;
    localparam int unsigned CW = (N_ITER > 1) ? $clog2(N_ITER) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(N_ITER - 1);

    state_t              state;
    state_t              state_next;
    logic [CW-1:0]       cnt;
    logic [CW-1:0]       cnt_next;
    logic signed [W-1:0] x_acc;
    logic signed [W-1:0] y_acc;
    logic signed [IW-1:0] z_acc;
    logic signed [W-1:0] x_acc_next;
    logic signed [W-1:0] y_acc_next;
    logic signed [IW-1:0] z_acc_next;
    logic signed [IW-1:0] x_o_next;
    logic signed [IW-1:0] y_o_next;
    logic signed [IW-1:0] z_o_next;
    logic                valid_next;
    logic                busy_next;

    logic signed [W-1:0] x_map;
    logic signed [W-1:0] y_map;
    logic signed [IW-1:0] z_map;
    logic signed [W-1:0] x_shift;
    logic signed [W-1:0] y_shift;
    logic signed [W-1:0] x_rot;
    logic signed [W-1:0] y_rot;
    logic signed [IW-1:0] atan_val;
    logic signed [IW-1:0] z_rot;
    logic signed [W-1:0] x_fin;
    logic signed [W-1:0] y_fin;
    logic signed [IW-1:0] z_fin;
    logic signed [IW-1:0] x_sat;
    logic signed [IW-1:0] y_sat;

    cordic_rotator_seq_quadrant_map #(
        .N_FRAC (N_FRAC)
    ) u_quadrant_map (
        .x       (x_i),
        .y       (y_i),
        .z       (z_i),
        .x_map_c (x_map),
        .y_map_c (y_map),
        .z_map_c (z_map)
    );

    // One micro-rotation: direction follows the sign of the residual angle
    always_comb begin
        x_shift  = x_acc >>> cnt;
        y_shift  = y_acc >>> cnt;
        atan_val = IW'(atan_lut(32'(cnt), N_FRAC));
        if (z_acc[IW-1] == 1'b0) begin
            x_rot = x_acc - y_shift;
            y_rot = y_acc + x_shift;
            z_rot = z_acc - atan_val;
        end else begin
            x_rot = x_acc + y_shift;
            y_rot = y_acc - x_shift;
            z_rot = z_acc + atan_val;
        end
    end

`ifdef CORDIC_GAIN_COMP_EN
    // Shift-add 1/K ~= 0.6074 applied to the finished vector
    always_comb begin
        x_fin = (x_acc >>> 1) + (x_acc >>> 3) - (x_acc >>> 6) - (x_acc >>> 9);
        y_fin = (y_acc >>> 1) + (y_acc >>> 3) - (y_acc >>> 6) - (y_acc >>> 9);
        z_fin = z_acc;
    end
`else
    // Result is taken straight from the last micro-rotation
    always_comb begin
        x_fin = x_rot;
        y_fin = y_rot;
        z_fin = z_rot;
    end
`endif

    // Clamp the guard-bit result into the output word
    always_comb begin
        x_sat = IW'(saturate(32'(x_fin), N_FRAC));
        y_sat = IW'(saturate(32'(y_fin), N_FRAC));
    end

    // Next-state and next-output logic
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        x_acc_next = x_acc;
        y_acc_next = y_acc;
        z_acc_next = z_acc;
        x_o_next   = x_o;
        y_o_next   = y_o;
        z_o_next   = z_o;
        valid_next = 1'b0;
        busy_next  = busy_o;
        case (state)
            ST_IDLE: begin
                if (data_in_valid_strobe_i) begin
                    x_acc_next = x_map;
                    y_acc_next = y_map;
                    z_acc_next = z_map;
                    cnt_next   = '0;
                    busy_next  = 1'b1;
                    state_next = ST_ROTATE;
                end
            end
            ST_ROTATE: begin
                x_acc_next = x_rot;
                y_acc_next = y_rot;
                z_acc_next = z_rot;
                cnt_next   = cnt + CW'(1);
                if (cnt == CNT_LAST) begin
`ifdef CORDIC_GAIN_COMP_EN
                    state_next = ST_SCALE;
`else
                    state_next = ST_IDLE;
                    busy_next  = 1'b0;
                    valid_next = 1'b1;
                    x_o_next   = x_sat;
                    y_o_next   = y_sat;
                    z_o_next   = z_fin;
`endif
                end
            end
`ifdef CORDIC_GAIN_COMP_EN
            ST_SCALE: begin
                state_next = ST_IDLE;
                busy_next  = 1'b0;
                valid_next = 1'b1;
                x_o_next   = x_sat;
                y_o_next   = y_sat;
                z_o_next   = z_fin;
            end
`endif
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // State, datapath and output registers with synchronous reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state                   <= ST_IDLE;
            cnt                     <= '0;
            x_acc                   <= '0;
            y_acc                   <= '0;
            z_acc                   <= '0;
            x_o                     <= '0;
            y_o                     <= '0;
            z_o                     <= '0;
            data_out_valid_strobe_o <= 1'b0;
            busy_o                  <= 1'b0;
        end else begin
            state                   <= state_next;
            cnt                     <= cnt_next;
            x_acc                   <= x_acc_next;
            y_acc                   <= y_acc_next;
            z_acc                   <= z_acc_next;
            x_o                     <= x_o_next;
            y_o                     <= y_o_next;
            z_o                     <= z_o_next;
            data_out_valid_strobe_o <= valid_next;
            busy_o                  <= busy_next;
        end
    end

endmodule
